// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - 8N1 UART transmitter with level ready (next) and one-cycle byte strobe
module uart_tx #(
  parameter int CLK_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [7:0] dout,
  input  logic       dout_ready,
  output logic       txd,
  output logic       next
);

  localparam int CW = $clog2(CLK_PER_BIT);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_PER_BIT - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;
  logic          bit_done;

  assign bit_done = (cnt == CNT_LAST);
  assign next     = (state == IDLE);

  // txd is registered so the line only moves on clock edges, except the async return to idle on reset
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= IDLE;
      txd     <= 1'b1;
      cnt     <= '0;
      bit_idx <= '0;
      shift   <= '0;
    end else begin
      case (state)
        IDLE: begin
          txd <= 1'b1;
          if (dout_ready) begin
            shift <= dout;
            txd   <= 1'b0;
            cnt   <= '0;
            state <= START;
          end
        end
        START: begin
          if (bit_done) begin
            cnt     <= '0;
            txd     <= shift[0];
            bit_idx <= '0;
            state   <= DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (bit_done) begin
            cnt <= '0;
            if (bit_idx == 3'd7) begin
              txd   <= 1'b1;
              state <= STOP;
            end else begin
              // shift[0] always holds the bit on the line; drop it and present the next one
              bit_idx <= bit_idx + 1'b1;
              shift   <= {1'b0, shift[7:1]};
              txd     <= shift[1];
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STOP: begin
          if (bit_done) begin
            cnt   <= '0;
            state <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          txd   <= 1'b1;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - scoreboard bench for uart_tx: a line decoder checks frames against queued bytes
module tb_uart_tx;

  localparam int N = 4;

  logic       clk;
  logic       rstn;
  logic [7:0] dout;
  logic       dout_ready;
  logic       txd;
  logic       nxt;

  int errors = 0;
  int checks = 0;
  int frames = 0;
  int cyc    = 0;
  int last_accept = 0;
  logic [7:0] exp_q[$];

  uart_tx #(.CLK_PER_BIT(N)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .dout      (dout),
    .dout_ready(dout_ready),
    .txd       (txd),
    .next      (nxt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference receiver: frame bit k is the line value in the middle of cycles k*N..k*N+N-1
  initial begin : monitor
    logic [9:0] bits;
    logic       aborted;
    logic       nxt_pre;
    forever begin
      @(negedge clk);
      if (rstn && !txd) begin
        bits    = '0;
        aborted = 1'b0;
        nxt_pre = 1'b1;
        for (int c = 1; c <= 10 * N; c++) begin
          @(negedge clk);
          if (!rstn) begin
            aborted = 1'b1;
            break;
          end
          if (c % N == N / 2) bits[c / N] = txd;
          if (c == 10 * N - 1) nxt_pre = nxt;
        end
        if (!aborted) begin
          frames++;
          check("start_bit", {31'd0, bits[0]}, 32'd0);
          check("stop_bit", {31'd0, bits[9]}, 32'd1);
          check("next_low_before_end", {31'd0, nxt_pre}, 32'd0);
          check("next_high_at_10_bits", {31'd0, nxt}, 32'd1);
          if (exp_q.size() == 0) check("unexpected_frame", {24'd0, bits[8:1]}, 32'hFFFF_FFFF);
          else check("frame_byte", {24'd0, bits[8:1]}, {24'd0, exp_q.pop_front()});
        end
      end
    end
  end

  // Called at a negedge; waits for next, strobes one byte, returns at the negedge after acceptance
  task automatic send_byte(input logic [7:0] b);
    int waited = 0;
    while (!nxt && waited < 20 * N) begin
      @(negedge clk);
      waited++;
    end
    if (!nxt) begin
      check("send_wait_next", {31'd0, nxt}, 32'd1);
      return;
    end
    dout       = b;
    dout_ready = 1'b1;
    exp_q.push_back(b);
    @(negedge clk);
    last_accept = cyc;
    dout_ready  = 1'b0;
    dout        = 8'($urandom);
    check("next_low_after_accept", {31'd0, nxt}, 32'd0);
  endtask

  task automatic drain();
    int waited = 0;
    while ((exp_q.size() != 0 || !nxt) && waited < 30 * N) begin
      @(negedge clk);
      waited++;
    end
    check("drain_queue_empty", exp_q.size(), 32'd0);
  endtask

  initial begin : stimulus
    int bad;
    int t0, t1, t2;
    int f0;
    logic [7:0] b;
    rstn       = 1'b0;
    dout       = 8'h00;
    dout_ready = 1'b0;

    #23;
    check("reset_txd", {31'd0, txd}, 32'd1);
    check("reset_next", {31'd0, nxt}, 32'd1);
    #4 rstn = 1'b1;
    #1;
    check("release_txd", {31'd0, txd}, 32'd1);
    check("release_next", {31'd0, nxt}, 32'd1);
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (txd !== 1'b1 || nxt !== 1'b1) bad++;
    end
    check("idle_100_cycles_bad", bad, 32'd0);

    send_byte(8'h55);
    drain();
    send_byte(8'h01);
    drain();
    send_byte(8'h80);
    drain();

    // Strobe during a frame must neither corrupt it nor queue a second frame
    f0 = frames;
    send_byte(8'hA3);
    repeat (3 * N) @(negedge clk);
    dout       = 8'hFF;
    dout_ready = 1'b1;
    @(negedge clk);
    dout_ready = 1'b0;
    dout       = 8'h5A;
    drain();
    repeat (3 * N) @(negedge clk);
    check("ignored_strobe_frames", frames - f0, 32'd1);

    send_byte(8'h48);
    t0 = last_accept;
    send_byte(8'h69);
    t1 = last_accept;
    send_byte(8'h0A);
    t2 = last_accept;
    check("b2b_gap_1", t1 - t0, 10 * N + 1);
    check("b2b_gap_2", t2 - t1, 10 * N + 1);
    drain();

    for (int i = 0; i < 12; i++) begin
      b = 8'($urandom);
      send_byte(b);
      repeat ($urandom_range(0, 12)) begin
        @(negedge clk);
        if (!nxt && ($urandom_range(0, 3) == 0)) begin
          dout       = 8'($urandom);
          dout_ready = 1'b1;
        end else begin
          dout_ready = 1'b0;
        end
      end
      dout_ready = 1'b0;
    end
    drain();

    send_byte(8'h00);
    repeat (4 * N) @(negedge clk);
    check("bit3_line_low", {31'd0, txd}, 32'd0);
    #1 rstn = 1'b0;
    #1;
    check("async_reset_txd", {31'd0, txd}, 32'd1);
    check("async_reset_next", {31'd0, nxt}, 32'd1);
    @(negedge clk);
    exp_q.delete();
    #2 rstn = 1'b1;
    @(negedge clk);
    send_byte(8'h3C);
    drain();

    repeat (2 * N) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule
